hdr_stream_gen: RTL and testbench



---
 rtl/hdr_stream_gen.sv | 123 ++++++++++++
 tb/tb_hdr_stream_gen.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/hdr_stream_gen.sv
// Header serialiser: snapshots frame/PPS/seq on start, emits NUM_WORDS words; word 0 valid the cycle after start, held under back-pressure.
// Optional HDR_STREAM_CHECKSUM_EN: last word carries XOR of the preceding words (needs NUM_WORDS >= 5).
module hdr_stream_gen #(
  parameter int          DATA_W    = 32,
  parameter int          NUM_WORDS = 4,
  parameter logic [31:0] SYNC_WORD = 32'hA5A5_5A5A,
  parameter int          DROP_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hdr_start,
  input  logic [DATA_W-1:0] frame_count,
  input  logic [DATA_W-1:0] pps_count,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  output logic              busy,
  output logic [DROP_W-1:0] drop_count
);

  localparam int                 IDX_W    = $clog2(NUM_WORDS);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic [DATA_W-1:0]  SYNC     = DATA_W'(SYNC_WORD);

  if (NUM_WORDS < 4 || NUM_WORDS > 16) begin : g_len_chk
    $error("hdr_stream_gen: NUM_WORDS must be within 4..16");
  end

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   frame_q, pps_q, seq_snap_q, seq_q;
  logic [DROP_W-1:0]   drop_q, drop_d;
  logic                load;
  logic [DATA_W-1:0]   word;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (hdr_start) begin
          state_d = SEND;
          idx_d   = '0;
          load    = 1'b1;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) state_d = IDLE;
          else                   idx_d   = idx_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Starts that arrive mid-header are counted, never queued.
  always_comb begin
    drop_d = drop_q;
    if (hdr_start && state_q == SEND && drop_q != '1) drop_d = drop_q + DROP_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      frame_q    <= '0;
      pps_q      <= '0;
      seq_snap_q <= '0;
      seq_q      <= '0;
      drop_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      drop_q  <= drop_d;
      if (load) begin
        frame_q    <= frame_count;
        pps_q      <= pps_count;
        seq_snap_q <= seq_q;
        seq_q      <= seq_q + DATA_W'(1);
      end
    end
  end

`ifdef HDR_STREAM_CHECKSUM_EN
  if (NUM_WORDS < 5) begin : g_csum_chk
    $error("hdr_stream_gen: checksum build needs NUM_WORDS >= 5");
  end

  logic [DATA_W-1:0] csum_q;

  // Words between the seq word and the checksum are zero, so only four terms matter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_q <= '0;
    end else if (load) begin
      csum_q <= SYNC ^ frame_count ^ pps_count ^ seq_q;
    end
  end
`endif

  always_comb begin
    word = '0;
    if (idx_q == IDX_W'(0))      word = SYNC;
    else if (idx_q == IDX_W'(1)) word = frame_q;
    else if (idx_q == IDX_W'(2)) word = pps_q;
    else if (idx_q == IDX_W'(3)) word = seq_snap_q;
`ifdef HDR_STREAM_CHECKSUM_EN
    if (idx_q == LAST_IDX) word = csum_q;
`endif
  end

  assign out_valid  = (state_q == SEND);
  assign busy       = (state_q == SEND);
  assign out_last   = out_valid && (idx_q == LAST_IDX);
  assign out_data   = out_valid ? word : '0;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_hdr_stream_gen.sv
// Bench for hdr_stream_gen: default instance driven from a vector table with a word scoreboard, plus a NUM_WORDS=6 instance.
module tb_hdr_stream_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hdr_start = 1'b0;
  logic        start6 = 1'b0;
  logic [31:0] frame_count = '0;
  logic [31:0] pps_count = '0;
  logic        out_ready = 1'b1;
  logic [31:0] out_data, out_data6;
  logic        out_valid, out_last, busy, out_valid6, out_last6, busy6;
  logic [15:0] drop_count, drop_count6;

  always #5 clk = ~clk;

  hdr_stream_gen dut (
    .clk(clk), .rst(rst), .hdr_start(hdr_start), .frame_count(frame_count),
    .pps_count(pps_count), .out_ready(out_ready), .out_data(out_data),
    .out_valid(out_valid), .out_last(out_last), .busy(busy), .drop_count(drop_count)
  );

  hdr_stream_gen #(.NUM_WORDS(6)) dut6 (
    .clk(clk), .rst(rst), .hdr_start(start6), .frame_count(frame_count),
    .pps_count(pps_count), .out_ready(1'b1), .out_data(out_data6),
    .out_valid(out_valid6), .out_last(out_last6), .busy(busy6), .drop_count(drop_count6)
  );

  localparam logic [31:0] SYNC = 32'hA5A5_5A5A;

  typedef struct {
    logic [31:0] frame;
    logic [31:0] pps;
    int          stall_at;
    int          stall_len;
    int          ndrop;
    bit          chg;
    int          exp_cyc;
  } vec_t;

  typedef struct {
    logic [31:0] dat;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] seq_m = '0;
  int          drop_m = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  vec_t        vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h required %h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic push_hdr(input logic [31:0] f, input logic [31:0] p);
    exp_q.push_back('{SYNC, 1'b0});
    exp_q.push_back('{f, 1'b0});
    exp_q.push_back('{p, 1'b0});
    exp_q.push_back('{seq_m, 1'b1});
    seq_m = seq_m + 32'd1;
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_word: got %h, required no valid word", out_data);
        end else begin
          chk("word_data", out_data, exp_q[0].dat);
          chk("word_last", {31'd0, out_last}, {31'd0, exp_q[0].last});
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    int cyc;
    frame_count = v.frame;
    pps_count   = v.pps;
    out_ready   = 1'b1;
    hdr_start   = 1'b1;
    push_hdr(v.frame, v.pps);
    @(posedge clk); #1;
    hdr_start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    cyc = 0;
    while (busy && cyc < 200) begin
      out_ready = !(cyc >= v.stall_at && cyc < v.stall_at + v.stall_len);
      hdr_start = (cyc >= 1 && cyc <= v.ndrop);
      if (hdr_start && drop_m < 65535) drop_m++;
      if (v.chg && cyc == v.stall_at) frame_count = 32'h99;
      @(posedge clk); #1;
      cyc++;
    end
    hdr_start = 1'b0;
    out_ready = 1'b1;
    chk("hdr_cycles", cyc, v.exp_cyc);
    chk("drop_count", {16'd0, drop_count}, drop_m);
    chk("valid_after_hdr", {31'd0, out_valid}, 32'd0);
    chk("words_left", exp_q.size(), 32'd0);
  endtask

  initial begin
    vecs[0] = '{32'h10, 32'h20, 0, 0, 0, 1'b0, 4};
    vecs[1] = '{32'h10, 32'h20, 1, 3, 0, 1'b1, 7};
    vecs[2] = '{32'hDEAD_BEEF, 32'h1234_5678, 0, 0, 2, 1'b0, 4};
    vecs[3] = '{32'hFFFF_FFFF, 32'h0, 3, 2, 0, 1'b0, 6};
    vecs[4] = '{32'h1, 32'h2, 0, 1, 3, 1'b0, 5};
    vecs[5] = '{32'hCAFE_0001, 32'h8000_0000, 2, 4, 1, 1'b1, 8};

    fork
      monitor();
    join_none

    #12;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_last", {31'd0, out_last}, 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_drop", {16'd0, drop_count}, 32'd0);
    chk("rst_valid6", {31'd0, out_valid6}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    run_vec(vecs[0]);
    run_vec(vecs[1]);

    // Saturate the dropped-start counter while a header is stalled.
    frame_count = 32'h55;
    pps_count   = 32'h66;
    out_ready   = 1'b0;
    hdr_start   = 1'b1;
    push_hdr(32'h55, 32'h66);
    @(posedge clk); #1;
    for (int i = 0; i < 65537; i++) begin
      if (drop_m < 65535) drop_m++;
      @(posedge clk); #1;
    end
    hdr_start = 1'b0;
    chk("drop_saturated", {16'd0, drop_count}, drop_m);
    chk("drop_sat_ffff", {16'd0, drop_count}, 32'h0000_FFFF);
    out_ready = 1'b1;
    for (int i = 0; i < 20 && busy; i++) begin
      @(posedge clk); #1;
    end
    chk("sat_hdr_done", {31'd0, busy}, 32'd0);

    // Reset while word 2 is on the bus.
    frame_count = 32'h77;
    pps_count   = 32'h88;
    hdr_start   = 1'b1;
    push_hdr(32'h77, 32'h88);
    @(posedge clk); #1;
    hdr_start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_word2", out_data, 32'h88);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_last", {31'd0, out_last}, 32'd0);
    chk("arst_drop", {16'd0, drop_count}, 32'd0);
    exp_q.delete();
    seq_m  = '0;
    drop_m = 0;
    @(negedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 2; i < 6; i++) run_vec(vecs[i]);

    // Six-word instance: words 4 and 5 are zero, last only on word 5.
    frame_count = 32'hABCD;
    pps_count   = 32'h1234;
    start6      = 1'b1;
    @(posedge clk); #1;
    start6 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      logic [31:0] w6;
      w6 = (k == 0) ? SYNC : (k == 1) ? 32'hABCD : (k == 2) ? 32'h1234 : 32'h0;
      @(negedge clk);
      chk("n6_valid", {31'd0, out_valid6}, 32'd1);
      chk("n6_data", out_data6, w6);
      chk("n6_last", {31'd0, out_last6}, (k == 5) ? 32'd1 : 32'd0);
      @(posedge clk);
    end
    #1;
    chk("n6_idle_valid", {31'd0, out_valid6}, 32'd0);
    chk("n6_idle_busy", {31'd0, busy6}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
